m_series_encode: RTL and testbench
==================================

# m_series_encode

Rate-1/2, constraint-length-3 convolutional encoder fed by an on-chip m-sequence (PRBS-7) generator, running from a single clock. Each source bit is held for two clocks. The two encoder output bits are serialised onto `code` at one bit per clock: the G1 bit first, then the G2 bit. The block is the data-source-plus-channel-coder front end of the convolutional-code datapath. A downstream Viterbi decoder or BER checker consumes `code`.

## Interface
Parameters:
- `LFSR_SEED`, default 7'h7F: PRBS-7 reset state. Must be non-zero; zero is illegal.
- `G1`, default 3'b101: generator 1 (octal 5), first bit of each pair.
- `G2`, default 3'b111: generator 2 (octal 7), second bit of each pair.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `q`, out, 1: current m-sequence bit, equal to `lfsr[6]`. Combinational from the LFSR register.
- `code`, out, 1: registered serial encoder output.
- `code_sel`, out, 1: registered. 0 = `code` carries the G1 bit; 1 = `code` carries the G2 bit.
- `code_vld`, out, 1: registered. High once the first coded bit is present and stays high until reset.
- `bit_stb`, out, 1: combinational. High in cycles where a source bit is sampled, i.e. phase = 0 and not `rst`.

## Operation
- The LFSR implements PRBS-7, x^7+x^6+1.
  - Next state is `{lfsr[5:0], lfsr[6]^lfsr[5]}`.
  - The LFSR advances only in phase-0 cycles, so the period is 127 bits, or 254 clocks.
- Encoder state `sr[1:0]` holds the last two source bits, with `sr[0]` the most recent. Let u be the current source bit.
  - Register w = {u, sr[0], sr[1]}.
  - g1 = ^(w & G1); for the default G1 this is u^sr[1].
  - g2 = ^(w & G2); for the default G2 this is u^sr[0]^sr[1].
- Phase register `ph` toggles every non-reset clock.
- Phase-0 cycle, on the clock edge:
  - u is sampled.
  - `code` <= g1, `code_sel` <= 0, `code_vld` <= 1.
  - g2 is saved in the hold register `c2`.
  - `sr` <= {sr[0], u}.
  - LFSR advances.
  - `ph` <= 1.
- Phase-1 cycle, on the clock edge:
  - `code` <= c2, `code_sel` <= 1.
  - `ph` <= 0.
  - No other state changes.
- Source bit u is `q`, unless overridden by the configuration option below.
- Reset values:
  - lfsr = LFSR_SEED, so `q` = LFSR_SEED[6] (1 by default).
  - `sr` = 0, `c2` = 0, `ph` = 0.
  - `code` = 0, `code_sel` = 0, `code_vld` = 0.
  - `bit_stb` = 0 while `rst` is high.
- Reset asserted mid-pair: the half-emitted pair is discarded. All registers return to reset values on that edge, and encoding restarts at phase 0 after release.
- The all-zero LFSR state is unreachable from a non-zero seed.

## Timing
- First edge with `rst` low is a phase-0 edge: it samples u0, and the G1 bit of u0 appears on `code` after that edge.
- The G2 bit of u0 appears one clock later. The G1 bit of u1 follows one clock after that.
- Latency from the sampling edge: 1 clock to G1, 2 clocks to G2.
- Output rate: 2 code bits per source bit. `code_sel` alternates 0,1,0,1 continuously once `code_vld` = 1.
- `q` changes only after phase-0 edges. It is stable for 2 clocks.
- No backpressure; the output stream is free-running.

## Configuration
- Macro `MSEQ_ENC_EXT_DATA_EN`.
- Defined:
  - Adds ports `data_in` (in, 1) and `data_sel` (in, 1).
  - In a phase-0 cycle, u = `data_sel` ? `data_in` : `q`.
  - Both inputs are sampled only in phase-0 cycles. The LFSR still advances regardless of `data_sel`.
- Not defined: those ports are absent and u = `q` always.

## Test plan
- Reset: hold `rst` 3 clocks. Required values: `code` = 0, `code_sel` = 0, `code_vld` = 0, `bit_stb` = 0, `q` = 1. `code_vld` rises after the first edge following release.
- Impulse (`MSEQ_ENC_EXT_DATA_EN`, `data_sel` = 1): data 1,0,0,0 at successive phase-0 edges gives `code` = 1,1,0,1,1,1,0,0. `code_sel` = 0,1,0,1,…
- All-zero input (`MSEQ_ENC_EXT_DATA_EN`, `data_sel` = 1, `data_in` = 0) for 20 bits gives `code` = 0 throughout.
- PRBS: sample `q` on 254 consecutive `bit_stb` cycles. Required: period exactly 127, 64 ones per period, and the first 7 bits equal 1,1,1,1,1,1,1 from the default seed.
- Encoder check: compare `code` against a golden (7,5) model driven by the sampled `q` stream over 300 clocks. Zero mismatches.
- Mid-pair reset: assert `rst` for 1 clock on a phase-1 cycle. Required: all outputs return to reset values, and the output stream after release is bit-identical to the stream after the initial reset.

Source files
------------

// File: rtl/m_series_encode.sv
// m_series_encode: PRBS-7 (x^7+x^6+1) data source feeding a rate-1/2, K=3
// convolutional encoder. Each source bit is held for two clocks; the G1 bit
// then the G2 bit are serialised onto `code`, one bit per clock.
// Optional feature macro: MSEQ_ENC_EXT_DATA_EN adds data_in/data_sel so an
// external bit can replace the m-sequence as the encoder source.
module m_series_encode #(
  parameter logic [6:0] LFSR_SEED = 7'h7F,
  parameter logic [2:0] G1        = 3'b101,
  parameter logic [2:0] G2        = 3'b111
) (
  input  logic clk,
  input  logic rst,
  output logic q,
  output logic code,
  output logic code_sel,
  output logic code_vld,
  output logic bit_stb
`ifdef MSEQ_ENC_EXT_DATA_EN
  ,
  input  logic data_in,
  input  logic data_sel
`endif
);

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned K_W    = 3;

  logic [LFSR_W-1:0] lfsr;
  logic [1:0]        sr;
  logic              c2;
  logic              ph;
  logic              u;
  logic [K_W-1:0]    w;
  logic              g1;
  logic              g2;

  // Current m-sequence bit and the source-sample strobe.
  assign q       = lfsr[LFSR_W-1];
  assign bit_stb = !ph && !rst;

  // Source selection and generator taps over {u, sr[0], sr[1]}.
  always_comb begin
    u = q;
`ifdef MSEQ_ENC_EXT_DATA_EN
    if (data_sel) u = data_in;
`endif
    w  = {u, sr[0], sr[1]};
    g1 = ^(w & G1);
    g2 = ^(w & G2);
  end

  // Phase 0 samples u, emits G1 and parks G2; phase 1 emits the parked G2.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      sr       <= 2'b00;
      c2       <= 1'b0;
      ph       <= 1'b0;
      code     <= 1'b0;
      code_sel <= 1'b0;
      code_vld <= 1'b0;
    end else if (!ph) begin
      lfsr     <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};
      sr       <= {sr[0], u};
      c2       <= g2;
      code     <= g1;
      code_sel <= 1'b0;
      code_vld <= 1'b1;
      ph       <= 1'b1;
    end else begin
      code     <= c2;
      code_sel <= 1'b1;
      ph       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_series_encode.sv
// Scoreboard bench for m_series_encode: a driver pushes expected code pairs and
// m-sequence bits computed from a recurrence-based PRBS model and a generator
// polynomial model; a negedge monitor pops and compares.
module tb_m_series_encode;

  localparam logic [6:0] SEED = 7'h7F;
  localparam logic [2:0] GEN1 = 3'b101;
  localparam logic [2:0] GEN2 = 3'b111;

  logic clk;
  logic rst;
  logic q, code, code_sel, code_vld, bit_stb;
`ifdef MSEQ_ENC_EXT_DATA_EN
  logic data_in;
  logic data_sel;
`endif

  m_series_encode #(.LFSR_SEED(SEED), .G1(GEN1), .G2(GEN2)) dut (
    .clk      (clk),
    .rst      (rst),
    .q        (q),
    .code     (code),
    .code_sel (code_sel),
    .code_vld (code_vld),
    .bit_stb  (bit_stb)
`ifdef MSEQ_ENC_EXT_DATA_EN
    ,
    .data_in  (data_in),
    .data_sel (data_sel)
`endif
  );

  int total = 0;
  int bad   = 0;
  int seg   = 0;
  bit act_code = 0;
  bit act_q    = 0;
  logic rst_q  = 1'b0;

  logic [1:0] cq[$];   // {sel, code}
  logic       qq[$];
  bit         qlog[$];
  bit         log1[$];
  bit         log2[$];

  bit prbs[0:1023];
  int k;
  bit src[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Encoder output of generator g for the newest source bit, from the source history.
  function automatic bit gen_bit(input logic [2:0] g);
    int n;
    bit p1, p2;
    n  = src.size() - 1;
    p1 = (n >= 1) ? src[n-1] : 1'b0;
    p2 = (n >= 2) ? src[n-2] : 1'b0;
    return (g[2] & src[n]) ^ (g[1] & p1) ^ (g[0] & p2);
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Monitor: compare against the scoreboard away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    logic       eq;
    if (act_q && bit_stb) begin
      if (qq.size() == 0) check("q_unexpected_stb", 32'(1), 32'(0));
      else begin
        eq = qq.pop_front();
        check("q", 32'(q), 32'(eq));
        if (seg == 1) qlog.push_back(q);
      end
    end
    if (rst_q) begin
      check("rst_code", 32'(code), 32'(0));
      check("rst_code_sel", 32'(code_sel), 32'(0));
      check("rst_code_vld", 32'(code_vld), 32'(0));
      check("rst_q", 32'(q), 32'(SEED[6]));
      if (rst) check("rst_bit_stb", 32'(bit_stb), 32'(0));
    end else if (act_code) begin
      check("code_vld", 32'(code_vld), 32'(1));
      if (cq.size() == 0) check("code_unexpected", 32'(1), 32'(0));
      else begin
        e = cq.pop_front();
        check("code", 32'(code), 32'(e[0]));
        check("code_sel", 32'(code_sel), 32'(e[1]));
        if (seg == 1) log1.push_back(code);
        if (seg == 2) log2.push_back(code);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step();
    cq.delete();
    qq.delete();
    for (int i = 1; i < n; i++) step();
    rst = 1'b0;
    k = 0;
    src.delete();
    seg++;
    act_code = 1;
    act_q    = 1;
  endtask

`ifdef MSEQ_ENC_EXT_DATA_EN
  // mode 0: m-sequence, 1: impulse, 2: random external/internal mix, 3: external zeros
  task automatic push_bit(input int mode, input bit first);
    bit u;
    case (mode)
      1:       begin data_sel = 1'b1; data_in = first; end
      2:       begin data_sel = 1'($urandom); data_in = 1'($urandom); end
      3:       begin data_sel = 1'b1; data_in = 1'b0; end
      default: begin data_sel = 1'b0; data_in = 1'($urandom); end
    endcase
    u = data_sel ? data_in : prbs[k];
    src.push_back(u);
    cq.push_back({1'b0, gen_bit(GEN1)});
    cq.push_back({1'b1, gen_bit(GEN2)});
    qq.push_back(prbs[k]);
    k++;
  endtask

  task automatic run_bits(input int n, input int mode);
    for (int b = 0; b < n; b++) begin
      push_bit(mode, b == 0);
      step();
      data_in  = 1'($urandom);
      data_sel = 1'($urandom);
      step();
    end
  endtask
`else
  task automatic push_bit();
    src.push_back(prbs[k]);
    cq.push_back({1'b0, gen_bit(GEN1)});
    cq.push_back({1'b1, gen_bit(GEN2)});
    qq.push_back(prbs[k]);
    k++;
  endtask

  task automatic run_bits(input int n, input int mode);
    for (int b = 0; b < n + mode; b++) begin
      push_bit();
      step();
      step();
    end
  endtask
`endif

  initial begin
    int ones;
    rst = 1'b1;
`ifdef MSEQ_ENC_EXT_DATA_EN
    data_in  = 1'b0;
    data_sel = 1'b0;
`endif
    // q sequence: first 7 bits are the seed MSB-first, then a[n+7] = a[n]^a[n+1].
    for (int i = 0; i < 7; i++) prbs[i] = SEED[6-i];
    for (int n = 0; n + 7 < 1024; n++) prbs[n+7] = prbs[n] ^ prbs[n+1];

    do_reset(3);
    run_bits(260, 0);

`ifdef MSEQ_ENC_EXT_DATA_EN
    push_bit(0, 1'b0);
`else
    push_bit();
`endif
    step();
    do_reset(1);
    run_bits(40, 0);

`ifdef MSEQ_ENC_EXT_DATA_EN
    do_reset(2);
    run_bits(4, 1);
    run_bits(20, 3);
    run_bits(100, 2);
`else
    do_reset(int'($urandom_range(1, 4)));
    run_bits(int'($urandom_range(50, 100)), 0);
`endif

    act_q = 0;
    step();
    act_code = 0;
    check("code_queue_drained", 32'(cq.size()), 32'(0));
    check("q_queue_drained", 32'(qq.size()), 32'(0));

    check("prbs_samples", 32'(qlog.size() >= 254), 32'(1));
    if (qlog.size() >= 254) begin
      ones = 0;
      for (int i = 0; i < 127; i++) ones += int'(qlog[i]);
      check("prbs_ones", 32'(ones), 32'(64));
      for (int i = 0; i < 7; i++) check("prbs_first7", 32'(qlog[i]), 32'(1));
      for (int i = 0; i < 127; i++) check("prbs_period", 32'(qlog[i+127]), 32'(qlog[i]));
    end

    check("restart_len", 32'(log2.size() >= 80 && log1.size() >= 80), 32'(1));
    if (log2.size() >= 80 && log1.size() >= 80)
      for (int i = 0; i < 80; i++) check("restart_stream", 32'(log2[i]), 32'(log1[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
